// File: rtl/digit_scan_driver_pkg.sv
// digit_scan_pkg: shared constants, hex segment table and one-hot helper for digit_scan_driver
package digit_scan_pkg;
  localparam int BLANK_W = 4;
  localparam logic [3:0] FRAME_START = 4'b0001;
  localparam logic [3:0] LAST_PHASE = 4'b1000;
  // Active-high {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[n] is the pattern of hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic is_onehot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/digit_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-high 7-segment pattern
//   nibble in  4  hex digit
//   seg    out 7  {g,f,e,d,c,b,a}, active-high
module hex_to_seg7
  import digit_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: multiplexes a frame-latched 16-bit hex value onto four digits driven by a one-hot ring phase
//   Clock      in  1   rising-edge clock
//   Reset_n    in  1   asynchronous active-low reset
//   Phase      in  4   one-hot ring phase, Phase[i] selects digit i
//   Value      in  16  display value, digit i shows Value[4i+3:4i]
//   Dp_in      in  4   decimal point per digit
//   Load       in  1   level request to capture Value/Dp_in at the next frame boundary
//   Load_ack   out 1   one-cycle pulse when Value/Dp_in are captured
//   Frame_tick out 1   one-cycle pulse at each 1000->0001 boundary
//   Anode      out 4   digit enables
//   Seg        out 7   segments {g,f,e,d,c,b,a}
//   Dp         out 1   decimal point of the driven digit
//   Phase_err  out 1   sticky illegal-phase flag
module digit_scan_driver
  import digit_scan_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [3:0]  Phase,
  input  logic [15:0] Value,
  input  logic [3:0]  Dp_in,
  input  logic        Load,
  output logic        Load_ack,
  output logic        Frame_tick,
  output logic [3:0]  Anode,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Phase_err
);
  localparam logic POL = ACTIVE_LOW;
  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(BLANK_CYCLES);
  logic [3:0] phase_q;
  logic [BLANK_W-1:0] cnt_q, cnt_d;
  logic [15:0] shadow, shadow_d;
  logic [3:0] shadow_dp, shadow_dp_d, nibble;
  logic boundary, capture, drive, dp_sel;
  logic [6:0] seg_hi;
  // Outputs are registered from next-state values, so a change sampled at edge k
  // blanks from edge k and drives again exactly BLANK_CYCLES edges later.
  always_comb begin
    boundary = (Phase == FRAME_START) && (phase_q == LAST_PHASE);
    capture = boundary && Load;
    shadow_d = capture ? Value : shadow;
    shadow_dp_d = capture ? Dp_in : shadow_dp;
    cnt_d = (Phase != phase_q) ? BLANK_INIT : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    drive = (cnt_d == '0) && is_onehot(Phase);
    nibble = ({4{Phase[0]}} & shadow_d[3:0]) | ({4{Phase[1]}} & shadow_d[7:4]) |
             ({4{Phase[2]}} & shadow_d[11:8]) | ({4{Phase[3]}} & shadow_d[15:12]);
    dp_sel = |(Phase & shadow_dp_d);
  end
  hex_to_seg7 u_dec (
    .nibble(nibble),
    .seg(seg_hi)
  );
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= '0;
      cnt_q <= '0;
      shadow <= '0;
      shadow_dp <= '0;
      Anode <= {4{POL}};
      Seg <= {7{POL}};
      Dp <= POL;
      Load_ack <= 1'b0;
      Frame_tick <= 1'b0;
      Phase_err <= 1'b0;
    end else begin
      phase_q <= Phase;
      cnt_q <= cnt_d;
      shadow <= shadow_d;
      shadow_dp <= shadow_dp_d;
      Anode <= drive ? (Phase ^ {4{POL}}) : {4{POL}};
      Seg <= drive ? (seg_hi ^ {7{POL}}) : {7{POL}};
      Dp <= drive ? (dp_sel ^ POL) : POL;
      Load_ack <= capture;
      Frame_tick <= boundary;
      Phase_err <= Phase_err | ~is_onehot(Phase);
    end
  end
endmodule

// File: doc/digit_scan_driver.md
# digit_scan_driver

Display multiplexer that sits directly downstream of the 4-bit one-hot ring counter. It consumes the ring phase, drives the matching digit anode with the hex-decoded nibble of a frame-latched 16-bit value, and blanks all digits for a programmable dead time on every phase change. It also flags illegal (non-one-hot) phases and offers a level request/acknowledge handshake so new display values only take effect at frame boundaries.

## Interface
- BLANK_CYCLES, default 2: dead-time cycles, all digits off, after each phase change; legal range 0..15.
- ACTIVE_LOW, default 1: when 1, Anode, Seg and Dp are active-low; when 0, active-high.

- Clock  in  1  single clock; all state is updated on the rising edge.
- Reset_n  in  1  reset is asynchronous and active-low.
- Phase  in  4  one-hot ring phase; Phase[i] selects digit i.
- Value  in  16  display value; digit i shows Value[4i+3:4i].
- Dp_in  in  4  decimal point per digit; Dp_in[i] belongs to digit i.
- Load  in  1  level request to update the displayed value.
- Load_ack  out  1  one-cycle pulse when Value and Dp_in are captured.
- Frame_tick  out  1  one-cycle pulse at each frame boundary.
- Anode  out  4  digit enables.
- Seg  out  7  segments {g,f,e,d,c,b,a}.
- Dp  out  1  decimal point of the driven digit.
- Phase_err  out  1  sticky illegal-phase flag.

## Operation
- phase_q: register of Phase. Its reset value is 4'b0000, which is not flagged as an error.
- Phase change: at an edge where Phase != phase_q, the blank counter loads BLANK_CYCLES and the outputs go inactive.
  - A further change while blanking reloads the counter and restarts the dead time.
- Drive: when the blank counter is 0 and phase_q is one-hot:
  - Anode asserts only bit i, where phase_q[i] = 1.
  - Seg = decode(shadow[4i+3:4i]).
  - Dp = shadow_dp[i].
- Illegal phase: Phase with popcount != 1, sampled at any edge out of reset.
  - Phase_err sets and stays set until Reset_n is asserted.
  - Outputs stay inactive for as long as phase_q is illegal.
  - Legal phases resume normal driving; the flag stays set.
- Frame boundary: an edge where Phase == 4'b0001 and phase_q == 4'b1000.
  - Frame_tick pulses for one cycle.
  - 0000→0001 (first phase after reset) is not a boundary.
  - Any illegal→0001 transition is not a boundary.
- Handshake:
  - Load must be held high with Value and Dp_in stable until Load_ack.
  - At a frame boundary with Load = 1, the shadow and shadow_dp registers capture Value and Dp_in, and Load_ack pulses in the same cycle as Frame_tick.
  - Load dropped before a boundary withdraws the request; nothing is captured.
  - Load held high after an ack is a new request and is served at the next boundary.
- Decode: standard hex patterns, active-high form shown here; ACTIVE_LOW inverts them.
  - 0 → 0111111
  - 1 → 0000110
  - 8 → 1111111
  - A → 1110111
  - F → 1110001
- Reset values, with ACTIVE_LOW = 1:
  - Anode = 4'b1111, Seg = 7'b1111111, Dp = 1.
  - Load_ack = 0, Frame_tick = 0, Phase_err = 0.
  - shadow = 16'h0000, shadow_dp = 4'b0000, blank counter = 0.
- Reset mid-frame: everything returns to reset values immediately. A pending Load is dropped and must be re-presented by the requester.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Phase change sampled at edge k:
  - Outputs are inactive from edge k through edge k+BLANK_CYCLES-1.
  - The new digit is driven from edge k+BLANK_CYCLES.
  - With BLANK_CYCLES = 0, the new digit is driven at edge k with no dead time.
- Frame boundary at edge k:
  - Frame_tick and Load_ack are high for the cycle following edge k.
  - Digit 0 of the new frame shows the newly captured value once blanking ends.
- Phase_err asserts at the edge that samples the illegal Phase.
- Load and the boundary at the same edge: the capture happens at that edge.

## Structure
- Shared package `digit_scan_pkg` holds:
  - the 16-entry hex→segment constant table (active-high);
  - the blank counter width constant (4 bits);
  - the frame-start phase constant 4'b0001;
  - the last-phase constant 4'b1000.
- One combinational sub-module `hex_to_seg7`: 4-bit nibble in, 7-bit active-high pattern out, implemented from the package table.
- Polarity inversion is done in the top level, not in the sub-module.

## Test plan
- Reset, then ring sequence 0001→0010→0100→1000 advancing every 8 cycles, BLANK_CYCLES = 2, no Load:
  - Anode = 1111 for 2 cycles after each change, then 1110, 1101, 1011, 0111 in turn.
  - Seg = 1000000 (digit "0").
- Load = 1, Value = 16'hA810, Dp_in = 4'b0100 held high mid-frame:
  - No Load_ack until the 1000→0001 edge; there, Load_ack and Frame_tick pulse together.
  - Digits then show 0, 1, 8, A with Dp on digit 2 only.
- Load raised then dropped before the boundary:
  - No Load_ack; shadow keeps its old value.
- Phase = 4'b0110 injected for one cycle:
  - Phase_err goes to 1 and stays at 1.
  - Anode = 1111 while the illegal phase is held.
  - Normal driving resumes on the next legal phase.
  - 0110→0001 produces no Frame_tick.
- Phase toggling every cycle with BLANK_CYCLES = 3:
  - Anode stays 1111 until Phase holds for 3 cycles.
  - Repeat with BLANK_CYCLES = 0: Anode tracks phase_q every cycle.
- Reset_n asserted mid-frame while Load is pending:
  - Outputs return immediately to reset values; shadow = 0; Phase_err = 0; no Load_ack is issued.
